// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control FSM.
// Select codes here mirror the mux input order of the multi-cycle datapath.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JALR      = 4'd10,
        S_JAL_LINK  = 4'd11,
        S_LUI       = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_SUB = 2'd1,
        ALU_CLS_R   = 2'd2,
        ALU_CLS_I   = 2'd3
    } alu_cls_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // Branch condition from the subtract flags: beq, bne, blt, bge.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = s;
            3'b101:  branch_taken = !s;
            default: branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle: decode fields and flags in, selects and enables out.
// mem_req/mem_ready: an access is held while mem_req=1 and completes on the edge where mem_ready=1.
interface mc_ctrl_if;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       s;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_wr;
    logic       adr_source;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic [2:0] imm_source;
    logic [1:0] ALU_srcA;
    logic [1:0] ALU_srcB;
    logic [2:0] ALU_control;
    logic [1:0] result_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, f3, f7, z, s, mem_ready,
        output mem_req, mem_wr, adr_source, ir_wr, pc_wr, reg_wr, imm_source,
               ALU_srcA, ALU_srcB, ALU_control, result_source, illegal_op, state
    );

    modport slave (
        output op, f3, f7, z, s, mem_ready,
        input  mem_req, mem_wr, adr_source, ir_wr, pc_wr, reg_wr, imm_source,
               ALU_srcA, ALU_srcB, ALU_control, result_source, illegal_op, state
    );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU operation select from the controller's state class and funct fields.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   cls_i,
    input  logic [2:0] f3_i,
    input  logic [6:0] f7_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (cls_i)
            ALU_CLS_SUB: alu_control_o = ALU_SUB;
            ALU_CLS_R, ALU_CLS_I: begin
                case (f3_i)
                    // Only register-register ops honour funct7 for sub.
                    3'b000:  alu_control_o = (cls_i == ALU_CLS_R && f7_i == 7'b0100000) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control_o = ALU_AND;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b100:  alu_control_o = ALU_XOR;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and write-back
// over a shared ALU and a single memory port.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mc_ctrl_if.master  bus
);

    state_t     state_q, state_d;
    alu_cls_t   alu_cls;
    logic       mem_req_c, mem_wr_c, ir_wr_c, pc_wr_c, reg_wr_c, illegal_c;
    logic       adr_src;
    logic [2:0] imm_src;
    logic [1:0] src_a, src_b, res_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req_c = 1'b0;
        mem_wr_c  = 1'b0;
        ir_wr_c   = 1'b0;
        pc_wr_c   = 1'b0;
        reg_wr_c  = 1'b0;
        illegal_c = 1'b0;
        adr_src   = 1'b0;
        imm_src   = IMM_I;
        src_a     = SRCA_PC;
        src_b     = SRCB_B;
        res_src   = RES_ALUOUT;
        alu_cls   = ALU_CLS_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_b     = SRCB_FOUR;
                res_src   = RES_ALU;
                ir_wr_c   = bus.mem_ready;
                pc_wr_c   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut as the branch/jal target.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                if (bus.op == OP_BR)       imm_src = IMM_B;
                else if (bus.op == OP_JAL) imm_src = IMM_J;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL_LINK;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                src_a   = SRCA_A;
                src_b   = SRCB_IMM;
                imm_src = (bus.op == OP_SW) ? IMM_S : IMM_I;
                state_d = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                res_src  = RES_DATA;
                reg_wr_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req_c = 1'b1;
                mem_wr_c  = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                src_a   = SRCA_A;
                src_b   = SRCB_B;
                alu_cls = ALU_CLS_R;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a   = SRCA_A;
                src_b   = SRCB_IMM;
                alu_cls = ALU_CLS_I;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_wr_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = SRCA_A;
                src_b   = SRCB_B;
                alu_cls = ALU_CLS_SUB;
                pc_wr_c = branch_taken(bus.f3, bus.z, bus.s);
                state_d = S_FETCH;
            end
            S_JALR: begin
                src_a   = SRCA_A;
                src_b   = SRCB_IMM;
                state_d = S_JAL_LINK;
            end
            S_JAL_LINK: begin
                // PC takes the target from ALUOut while the ALU forms the link OldPC+4.
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_FOUR;
                pc_wr_c = 1'b1;
                state_d = S_ALU_WB;
            end
            S_LUI: begin
                imm_src  = IMM_U;
                res_src  = RES_IMM;
                reg_wr_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .cls_i         (alu_cls),
        .f3_i          (bus.f3),
        .f7_i          (bus.f7),
        .alu_control_o (bus.ALU_control)
    );

    // Enables are masked by reset directly so they drop without waiting for an edge.
    assign bus.mem_req       = rst_n & mem_req_c;
    assign bus.mem_wr        = rst_n & mem_wr_c;
    assign bus.ir_wr         = rst_n & ir_wr_c;
    assign bus.pc_wr         = rst_n & pc_wr_c;
    assign bus.reg_wr        = rst_n & reg_wr_c;
    assign bus.illegal_op    = rst_n & illegal_c;
    assign bus.adr_source    = adr_src;
    assign bus.imm_source    = imm_src;
    assign bus.ALU_srcA      = src_a;
    assign bus.ALU_srcB      = src_b;
    assign bus.result_source = res_src;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, reset corner cases and
// randomized instructions checked against a per-instruction cycle-trace model.
module tb_mc_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mc_ctrl_if bus ();

    mc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Per-cycle record: {state, ALU_control, reg_wr, mem_req, mem_wr, adr_source}
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];

    int         o_cyc, o_reg, o_pc, o_ir, o_mw, o_ill;
    logic [2:0] o_alu;
    logic [1:0] jl_a, jl_b;
    logic       jl_pc;

    int         m_cyc, m_reg, m_pc, m_mw, m_ill;
    logic [2:0] m_alu;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        logic       s;
        int         wf;
        int         wm;
        int         cyc;
        int         reg_n;
        int         pc_n;
        int         mw_n;
        int         ill_n;
        logic [2:0] alu;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic [3:0] st, input logic [2:0] alu);
        logic w, r, mw, ad;
        w  = (st == 4'd4) || (st == 4'd8) || (st == 4'd12);
        r  = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
        mw = (st == 4'd5);
        ad = (st == 4'd3) || (st == 4'd5);
        return {st, alu, w, r, mw, ad};
    endfunction

    // Reference: the state walk of one instruction and its write counts.
    task automatic build_model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic s, input int wf, input int wm);
        logic [2:0] xa;
        int         tk;
        exp_q.delete();
        case (f3)
            3'b000:  xa = (op == 7'b0110011 && f7 == 7'b0100000) ? 3'b001 : 3'b000;
            3'b111:  xa = 3'b010;
            3'b110:  xa = 3'b011;
            3'b010:  xa = 3'b101;
            3'b100:  xa = 3'b100;
            default: xa = 3'b000;
        endcase
        tk = 0;
        if ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && s) || (f3 == 3'b101 && !s)) tk = 1;
        for (int i = 0; i <= wf; i++) exp_q.push_back(pk(4'd0, 3'b000));
        exp_q.push_back(pk(4'd1, 3'b000));
        m_reg = 1; m_pc = 1; m_mw = 0; m_ill = 0; m_alu = 3'b000;
        case (op)
            7'b0000011: begin
                exp_q.push_back(pk(4'd2, 3'b000));
                for (int i = 0; i <= wm; i++) exp_q.push_back(pk(4'd3, 3'b000));
                exp_q.push_back(pk(4'd4, 3'b000));
            end
            7'b0100011: begin
                exp_q.push_back(pk(4'd2, 3'b000));
                for (int i = 0; i <= wm; i++) exp_q.push_back(pk(4'd5, 3'b000));
                m_reg = 0;
                m_mw  = wm + 1;
            end
            7'b0110011: begin
                exp_q.push_back(pk(4'd6, xa));
                exp_q.push_back(pk(4'd8, 3'b000));
                m_alu = xa;
            end
            7'b0010011: begin
                exp_q.push_back(pk(4'd7, xa));
                exp_q.push_back(pk(4'd8, 3'b000));
                m_alu = xa;
            end
            7'b1100011: begin
                exp_q.push_back(pk(4'd9, 3'b001));
                m_reg = 0;
                m_pc  = 1 + tk;
            end
            7'b1101111: begin
                exp_q.push_back(pk(4'd11, 3'b000));
                exp_q.push_back(pk(4'd8, 3'b000));
                m_pc = 2;
            end
            7'b1100111: begin
                exp_q.push_back(pk(4'd10, 3'b000));
                exp_q.push_back(pk(4'd11, 3'b000));
                exp_q.push_back(pk(4'd8, 3'b000));
                m_pc = 2;
            end
            7'b0110111: exp_q.push_back(pk(4'd12, 3'b000));
            default: begin
                m_reg = 0;
                m_ill = 1;
            end
        endcase
        m_cyc = exp_q.size();
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic s, input int wf, input int wm);
        int         fw, mw;
        logic [3:0] st;
        logic       left;
        fw = 0; mw = 0; left = 1'b0;
        obs_q.delete();
        o_cyc = 0; o_reg = 0; o_pc = 0; o_ir = 0; o_mw = 0; o_ill = 0;
        o_alu = 3'b000; jl_a = 2'b00; jl_b = 2'b00; jl_pc = 1'b0;
        bus.op = op; bus.f3 = f3; bus.f7 = f7; bus.z = z; bus.s = s;
        forever begin
            st = bus.state;
            if (st != 4'd0) left = 1'b1;
            if (left && st == 4'd0) break;
            if (o_cyc >= 60) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
            if (st == 4'd0) begin
                bus.mem_ready = (fw >= wf);
                fw++;
            end else if (st == 4'd3 || st == 4'd5) begin
                bus.mem_ready = (mw >= wm);
                mw++;
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            o_reg += int'(bus.reg_wr);
            o_pc  += int'(bus.pc_wr);
            o_ir  += int'(bus.ir_wr);
            o_mw  += int'(bus.mem_wr);
            o_ill += int'(bus.illegal_op);
            if (st == 4'd6 || st == 4'd7) o_alu = bus.ALU_control;
            if (st == 4'd11) begin
                jl_a = bus.ALU_srcA; jl_b = bus.ALU_srcB; jl_pc = bus.pc_wr;
            end
            obs_q.push_back({st, bus.ALU_control, bus.reg_wr, bus.mem_req, bus.mem_wr, bus.adr_source});
            o_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic compare_model(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) bad++;
        check({tag, "_trace_len"}, obs_q.size(), exp_q.size());
        check({tag, "_trace_bad"}, bad, 0);
        check({tag, "_reg_wr"}, o_reg, m_reg);
        check({tag, "_pc_wr"}, o_pc, m_pc);
        check({tag, "_ir_wr"}, o_ir, 1);
        check({tag, "_mem_wr"}, o_mw, m_mw);
        check({tag, "_illegal"}, o_ill, m_ill);
        check({tag, "_alu"}, o_alu, m_alu);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op           f3      f7           z     s    wf wm cyc reg pc mw ill alu
        vt[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 4, 1, 1, 0, 0, 3'b000};
        vt[1]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 0, 0, 4, 1, 1, 0, 0, 3'b001};
        vt[2]  = '{7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0, 0, 0, 4, 1, 1, 0, 0, 3'b000};
        vt[3]  = '{7'b0010011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1, 0, 5, 1, 1, 0, 0, 3'b101};
        vt[4]  = '{7'b0110011, 3'b110, 7'b0000000, 1'b0, 1'b0, 0, 0, 4, 1, 1, 0, 0, 3'b011};
        vt[5]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 2, 1, 8, 1, 1, 0, 0, 3'b000};
        vt[6]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 0, 2, 6, 0, 1, 3, 0, 3'b000};
        vt[7]  = '{7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0, 0, 0, 3, 0, 2, 0, 0, 3'b000};
        vt[8]  = '{7'b1100011, 3'b001, 7'b0000000, 1'b1, 1'b0, 0, 0, 3, 0, 1, 0, 0, 3'b000};
        vt[9]  = '{7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1, 0, 0, 3, 0, 1, 0, 0, 3'b000};
        vt[10] = '{7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b1, 0, 0, 3, 0, 2, 0, 0, 3'b000};
        vt[11] = '{7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 5, 1, 2, 0, 0, 3'b000};
        vt[12] = '{7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 4, 1, 2, 0, 0, 3'b000};
        vt[13] = '{7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 3, 1, 1, 0, 0, 3'b000};
        vt[14] = '{7'b0001111, 3'b000, 7'b0000000, 1'b0, 1'b0, 0, 0, 2, 0, 1, 0, 1, 3'b000};

        // Reset: enables held low even with mem_ready high, selects at FETCH values.
        bus.op = 7'd0; bus.f3 = 3'd0; bus.f7 = 7'd0; bus.z = 1'b0; bus.s = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check("rst_state", bus.state, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_ir_pc_wr", {bus.ir_wr, bus.pc_wr}, 0);
        check("rst_srcB", bus.ALU_srcB, 2);
        check("rst_result_source", bus.result_source, 2);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, vt[i].s, vt[i].wf, vt[i].wm);
            check($sformatf("vec%0d_cycles", i), o_cyc, vt[i].cyc);
            check($sformatf("vec%0d_reg_wr", i), o_reg, vt[i].reg_n);
            check($sformatf("vec%0d_pc_wr", i), o_pc, vt[i].pc_n);
            check($sformatf("vec%0d_ir_wr", i), o_ir, 1);
            check($sformatf("vec%0d_mem_wr", i), o_mw, vt[i].mw_n);
            check($sformatf("vec%0d_illegal", i), o_ill, vt[i].ill_n);
            check($sformatf("vec%0d_alu", i), o_alu, vt[i].alu);
            build_model(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, vt[i].s, vt[i].wf, vt[i].wm);
            check($sformatf("vec%0d_trace_len", i), obs_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
                if (obs_q[k] !== exp_q[k]) check($sformatf("vec%0d_trace%0d", i, k), obs_q[k], exp_q[k]);
        end

        // jalr link cycle: PC written while the ALU forms OldPC+4.
        run_instr(7'b1100111, 3'b000, 7'd0, 1'b0, 1'b0, 0, 0);
        check("jal_link_srcA", jl_a, 2'b01);
        check("jal_link_srcB", jl_b, 2'b10);
        check("jal_link_pc_wr", jl_pc, 1'b1);

        // Reset mid-store with the memory stalled.
        bus.op = 7'b0100011; bus.f3 = 3'b010; bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw_state_before_rst", bus.state, 5);
        check("sw_mem_req_wr", {bus.mem_req, bus.mem_wr}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", bus.state, 0);
        check("async_rst_mem_req_wr", {bus.mem_req, bus.mem_wr}, 2'b00);
        check("async_rst_adr_source", bus.adr_source, 0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_hold_writes", {bus.reg_wr, bus.pc_wr, bus.ir_wr, bus.mem_wr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(7'b0110011, 3'b000, 7'd0, 1'b0, 1'b0, 0, 0);
        build_model(7'b0110011, 3'b000, 7'd0, 1'b0, 1'b0, 0, 0);
        compare_model("post_rst");

        // Randomized instructions with random wait states and flags.
        for (int n = 0; n < 150; n++) begin
            logic [6:0] rop;
            logic [2:0] rf3;
            logic [6:0] rf7;
            logic       rz, rs;
            int         rwf, rwm;
            case ($urandom_range(0, 9))
                0: rop = 7'b0000011;
                1: rop = 7'b0100011;
                2: rop = 7'b0110011;
                3: rop = 7'b0010011;
                4: rop = 7'b1100011;
                5: rop = 7'b1101111;
                6: rop = 7'b1100111;
                7: rop = 7'b0110111;
                8: rop = 7'b1110011;
                default: rop = 7'b0000000;
            endcase
            rf3 = 3'($urandom_range(0, 7));
            rf7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom_range(0, 127));
            rz  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            rwf = $urandom_range(0, 3);
            rwm = $urandom_range(0, 3);
            build_model(rop, rf3, rf7, rz, rs, rwf, rwm);
            run_instr(rop, rf3, rf7, rz, rs, rwf, rwm);
            compare_model($sformatf("rnd%0d_op%07b", n, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
